puf_axil_eval_ctrl: RTL and testbench

AXI4-Lite slave controlling a parametrised array of arbiter/butterfly PUF cells for PS software. It presents a challenge, triggers the cells, waits a settle time, then repeats the evaluation a programmable number of times. A per-bit majority vote produces a stabilised response. It is the next generation of the four-register PUF AXI IP and sits between the AXI interconnect and the PUF cell array.

---
 rtl/puf_ctrl_pkg.sv | 46 ++++
 rtl/puf_vote_counter.sv | 53 +++++
 rtl/puf_axil_eval_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_puf_axil_eval_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_ctrl_pkg
//  Description : Shared definitions for the PUF evaluation controller:
//                register byte offsets, CTRL/STATUS bit positions, the
//                evaluation FSM state encoding and AXI response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package puf_ctrl_pkg;

    // Register byte offsets
    localparam int ADDR_CTRL     = 'h00;
    localparam int ADDR_STATUS   = 'h04;
    localparam int ADDR_NEVAL    = 'h08;
    localparam int ADDR_RESP     = 'h0C;
    localparam int ADDR_CHAL0    = 'h10;
    localparam int ADDR_RAW      = 'h20;
    localparam int ADDR_UNSTABLE = 'h24;

    // CTRL / STATUS bit indices
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_EVAL_LSB  = 8;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Evaluation FSM
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRIG   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_VOTE   = 3'd4
    } puf_state_e;

    // A programmed evaluation count of zero still performs one evaluation.
    function automatic logic [3:0] neval_effective(input logic [3:0] neval);
        return (neval == 4'd0) ? 4'd1 : neval;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_vote_counter.sv
`default_nettype none
// ============================================================================
//  Module      : puf_vote_counter
//  Description : One 5-bit ones counter per PUF channel with synchronous
//                clear and accumulate, plus a combinational per-bit majority
//                compare (2*ones > neval, ties resolve to 0).
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                clr                - zero all counters
//                acc                - add sample[i] to counter i
//                sample[RESP_W]     - sampled cell outputs
//                neval[4]           - effective evaluation count (1..15)
//                majority[RESP_W]   - voted result
//                eval_cnt, unstable - only with PUF_RAW_CAPTURE_EN
//  Options     : PUF_RAW_CAPTURE_EN adds the per-channel instability flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_vote_counter #(
    parameter int RESP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc,
    input  logic [RESP_W-1:0] sample,
    input  logic [3:0]        neval,
`ifdef PUF_RAW_CAPTURE_EN
    input  logic [3:0]        eval_cnt,
    output logic [RESP_W-1:0] unstable,
`endif
    output logic [RESP_W-1:0] majority
);

    for (genvar i = 0; i < RESP_W; i++) begin : g_ch
        logic [4:0] r_ones;

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_ones <= 5'd0;
            end else if (acc) begin
                r_ones <= r_ones + {4'd0, sample[i]};
            end
        end

        // Compare 2*ones against neval in 6 bits so an exact half is a tie (0).
        assign majority[i] = ({r_ones, 1'b0} > {2'b00, neval});

`ifdef PUF_RAW_CAPTURE_EN
        assign unstable[i] = (r_ones != 5'd0) && (r_ones != {1'b0, eval_cnt});
`endif
    end

endmodule
`default_nettype wire

// File: rtl/puf_axil_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_axil_eval_ctrl
//  Description : AXI4-Lite slave driving an array of PUF cells. Presents a
//                challenge, pulses the trigger, waits SETTLE_CYCLES, samples
//                the response and repeats NEVAL times; a per-bit majority
//                vote yields the stabilised response.
//  Ports       : ACLK, ARESET       - clock, synchronous active-high reset
//                S_AXI_*            - AXI4-Lite slave (32-bit, WSTRB ignored)
//                puf_challenge      - challenge to the cells
//                puf_trigger        - one-cycle evaluation pulse
//                puf_response       - cell outputs
//  Options     : PUF_RAW_CAPTURE_EN adds RAW (0x20) and UNSTABLE (0x24);
//                without it those offsets read as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_axil_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int CHAL_W             = 64,
    parameter int RESP_W             = 32,
    parameter int SETTLE_CYCLES      = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [CHAL_W-1:0]             puf_challenge,
    output logic                          puf_trigger,
    input  logic [RESP_W-1:0]             puf_response
);

    localparam int c_word_w = C_S_AXI_ADDR_WIDTH - 2;
    localparam int c_nw     = CHAL_W / 32;
    localparam int c_sc_w   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_word_w-1:0] c_w_ctrl     = c_word_w'(ADDR_CTRL >> 2);
    localparam logic [c_word_w-1:0] c_w_status   = c_word_w'(ADDR_STATUS >> 2);
    localparam logic [c_word_w-1:0] c_w_neval    = c_word_w'(ADDR_NEVAL >> 2);
    localparam logic [c_word_w-1:0] c_w_resp     = c_word_w'(ADDR_RESP >> 2);
`ifdef PUF_RAW_CAPTURE_EN
    localparam logic [c_word_w-1:0] c_w_raw      = c_word_w'(ADDR_RAW >> 2);
    localparam logic [c_word_w-1:0] c_w_unstable = c_word_w'(ADDR_UNSTABLE >> 2);
`endif
    localparam logic [c_sc_w-1:0]   c_settle_last = c_sc_w'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    puf_state_e          r_state, w_next_state;
    logic                r_wr_ready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]          r_bresp;
    logic [31:0]         r_rdata;
    logic [CHAL_W-1:0]   r_chal;
    logic [3:0]          r_neval;
    logic [3:0]          r_eval_cnt;
    logic                r_done;
    logic [RESP_W-1:0]   r_resp;
    logic [c_sc_w-1:0]   r_settle_cnt;

    logic [c_word_w-1:0] w_aw_word, w_ar_word;
    logic                w_wr_en, w_busy, w_wr_chal, w_wr_err;
    logic                w_start, w_abort, w_acc;
    logic [3:0]          w_neval_eff;
    logic [RESP_W-1:0]   w_majority;
    logic [31:0]         w_rdata, w_status;

    assign w_aw_word   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_word   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_busy      = (r_state != ST_IDLE);
    assign w_neval_eff = neval_effective(r_neval);

    // A write transfers on the single cycle AWREADY/WREADY are high.
    assign w_wr_en = r_wr_ready & S_AXI_AWVALID & S_AXI_WVALID;

    always_comb begin
        w_wr_chal = 1'b0;
        for (int k = 0; k < c_nw; k++) begin
            if (w_aw_word == c_word_w'((ADDR_CHAL0 >> 2) + k)) w_wr_chal = 1'b1;
        end
    end

    assign w_wr_err = w_busy && (w_wr_chal || (w_aw_word == c_w_neval));

    // ABORT only acts outside IDLE; START only in IDLE and loses to ABORT.
    assign w_abort = w_wr_en && (w_aw_word == c_w_ctrl) &&
                     S_AXI_WDATA[CTRL_ABORT_BIT] && w_busy;
    assign w_start = w_wr_en && (w_aw_word == c_w_ctrl) &&
                     S_AXI_WDATA[CTRL_START_BIT] && !S_AXI_WDATA[CTRL_ABORT_BIT] &&
                     !w_busy;
    assign w_acc   = (r_state == ST_SAMPLE) && !w_abort;

    // ------------------------------------------------------------------
    // AXI write channel and writable registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_chal     <= '0;
            r_neval    <= 4'd0;
        end else begin
            r_wr_ready <= !r_wr_ready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            if (w_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!w_busy) begin
                    if (w_aw_word == c_w_neval) r_neval <= S_AXI_WDATA[3:0];
                    for (int k = 0; k < c_nw; k++) begin
                        if (w_aw_word == c_word_w'((ADDR_CHAL0 >> 2) + k))
                            r_chal[k*32 +: 32] <= S_AXI_WDATA;
                    end
                end
            end else if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Evaluation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next_state = ST_TRIG;
            ST_TRIG:   w_next_state = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == c_settle_last) w_next_state = ST_SAMPLE;
            ST_SAMPLE: begin
                if (({1'b0, r_eval_cnt} + 5'd1) < {1'b0, w_neval_eff})
                    w_next_state = ST_TRIG;
                else
                    w_next_state = ST_VOTE;
            end
            ST_VOTE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
        if (w_abort) w_next_state = ST_IDLE;
    end

    assign puf_trigger = (r_state == ST_TRIG);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_settle_cnt <= '0;
            r_eval_cnt   <= 4'd0;
            r_done       <= 1'b0;
            r_resp       <= '0;
        end else begin
            if (r_state == ST_TRIG)
                r_settle_cnt <= '0;
            else if (r_state == ST_SETTLE)
                r_settle_cnt <= r_settle_cnt + c_sc_w'(1);

            if (w_start)
                r_eval_cnt <= 4'd0;
            else if (w_acc)
                r_eval_cnt <= r_eval_cnt + 4'd1;

            if (w_start) begin
                r_done <= 1'b0;
            end else if ((r_state == ST_VOTE) && !w_abort) begin
                r_done <= 1'b1;
                r_resp <= w_majority;
            end
        end
    end

`ifdef PUF_RAW_CAPTURE_EN
    logic [RESP_W-1:0] r_raw, r_unstable, w_unstable;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_raw      <= '0;
            r_unstable <= '0;
        end else begin
            if (w_acc) r_raw <= puf_response;
            if (w_start)
                r_unstable <= '0;
            else if ((r_state == ST_VOTE) && !w_abort)
                r_unstable <= w_unstable;
        end
    end
`endif

    puf_vote_counter #(
        .RESP_W   (RESP_W)
    ) u_vote (
        .clk      (ACLK),
        .rst      (ARESET),
        .clr      (w_start),
        .acc      (w_acc),
        .sample   (puf_response),
        .neval    (w_neval_eff),
`ifdef PUF_RAW_CAPTURE_EN
        .eval_cnt (r_eval_cnt),
        .unstable (w_unstable),
`endif
        .majority (w_majority)
    );

    // ------------------------------------------------------------------
    // AXI read channel
    // ------------------------------------------------------------------
    always_comb begin
        w_status                          = '0;
        w_status[STATUS_BUSY_BIT]         = w_busy;
        w_status[STATUS_DONE_BIT]         = r_done;
        w_status[STATUS_EVAL_LSB +: 4]    = r_eval_cnt;
    end

    always_comb begin
        w_rdata = '0;
        if (w_ar_word == c_w_status) w_rdata = w_status;
        if (w_ar_word == c_w_neval)  w_rdata = {28'd0, r_neval};
        if (w_ar_word == c_w_resp)   w_rdata = 32'(r_resp);
        for (int k = 0; k < c_nw; k++) begin
            if (w_ar_word == c_word_w'((ADDR_CHAL0 >> 2) + k)) w_rdata = r_chal[k*32 +: 32];
        end
`ifdef PUF_RAW_CAPTURE_EN
        if (w_ar_word == c_w_raw)      w_rdata = 32'(r_raw);
        if (w_ar_word == c_w_unstable) w_rdata = 32'(r_unstable);
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= !r_arready && S_AXI_ARVALID && !r_rvalid;
            if (r_arready && S_AXI_ARVALID) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = r_wr_ready;
    assign S_AXI_WREADY  = r_wr_ready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign puf_challenge = r_chal;

    // Byte strobes and sub-word address bits carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_puf_axil_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_axil_eval_ctrl
//  Description : Directed self-checking bench for puf_axil_eval_ctrl.
//                A trigger monitor timestamps every puf_trigger pulse and
//                drives the next response word from a per-test table.
//  Options     : PUF_RAW_CAPTURE_EN selects the RAW/UNSTABLE expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_axil_eval_ctrl;

    localparam int SETTLE = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [63:0] puf_challenge;
    logic        puf_trigger;
    logic [31:0] puf_response = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trig_total = 0;
    int seq_base = 0;
    int last_bvalid_cyc = 0;
    int trig_time [0:63];
    logic [31:0] resp_seq [0:15];

    always #5 ACLK = ~ACLK;

    puf_axil_eval_ctrl #(
        .C_S_AXI_ADDR_WIDTH (6),
        .CHAL_W             (64),
        .RESP_W             (32),
        .SETTLE_CYCLES      (SETTLE)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (4'hF),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .puf_challenge (puf_challenge),
        .puf_trigger   (puf_trigger),
        .puf_response  (puf_response)
    );

    always @(posedge ACLK) cyc <= cyc + 1;

    // Timestamp each trigger and present the next response word.
    always @(negedge ACLK) begin
        if (puf_trigger === 1'b1) begin
            int idx;
            idx = trig_total - seq_base;
            trig_time[trig_total[5:0]] = cyc;
            puf_response = resp_seq[idx[3:0]];
            trig_total = trig_total + 1;
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        @(negedge ACLK);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(awready === 1'b1 && wready === 1'b1) && n < 20);
        @(posedge ACLK);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        last_bvalid_cyc = cyc;
        r = bresp;
        if (bvalid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL write_handshake addr=%h bvalid=%b required 1", a, bvalid);
        end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        @(negedge ACLK);
        araddr = a; arvalid = 1'b1;
        do begin
            @(negedge ACLK);
            n++;
        end while (arready !== 1'b1 && n < 20);
        @(posedge ACLK);
        #1;
        arvalid = 1'b0;
        d = rdata;
        r = rresp;
        if (rvalid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL read_handshake addr=%h rvalid=%b required 1", a, rvalid);
        end
    endtask

    task automatic wait_done(output logic [31:0] st);
        logic [1:0] r;
        int n;
        n = 0;
        do begin
            axi_read(6'h04, st, r);
            n++;
        end while (st[1] !== 1'b1 && n < 150);
        if (st[1] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout status=%h required DONE set", st);
        end
    endtask

    task automatic fill_seq(input logic [31:0] v);
        for (int i = 0; i < 16; i++) resp_seq[i] = v;
        seq_base = trig_total;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        ARESET = 1'b1;
        repeat (5) @(negedge ACLK);
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake bvalid=%b rvalid=%b awready=%b arready=%b required 0",
                     bvalid, rvalid, awready, arready);
        end
        ARESET = 1'b0;
        checks++;
        if (puf_challenge !== 64'd0) begin
            errors++; $display("FAIL reset_challenge got=%h required 0", puf_challenge);
        end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status got=%h required 0", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_resp got=%h required 0", d); end
        checks++;
        if (trig_total !== 0) begin errors++; $display("FAIL reset_trigger got=%0d required 0", trig_total); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [1:0]  r;
        int base, bv;
        axi_write(6'h10, 32'h0000_0001, r);
        axi_write(6'h14, 32'hDEAD_BEEF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL chal_bresp got=%b required 00", r); end
        checks++;
        if (puf_challenge !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL challenge got=%h required deadbeef00000001", puf_challenge);
        end
        axi_read(6'h14, d, r);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL chal_read got=%h required deadbeef", d); end
        axi_write(6'h08, 32'd5, r);
        fill_seq(32'h0000_00A5);
        base = trig_total;
        axi_write(6'h00, 32'h1, r);
        bv = last_bvalid_cyc;
        wait_done(d);
        checks++;
        if (trig_total - base !== 5) begin
            errors++; $display("FAIL basic_trig_count got=%0d required 5", trig_total - base);
        end
        checks++;
        if (trig_time[base[5:0]] !== bv) begin
            errors++; $display("FAIL first_trigger_cycle got=%0d required %0d", trig_time[base[5:0]], bv);
        end
        for (int k = 1; k < 5; k++) begin
            int a, b;
            a = base + k - 1;
            b = base + k;
            checks++;
            if (trig_time[b[5:0]] - trig_time[a[5:0]] !== SETTLE + 2) begin
                errors++;
                $display("FAIL trig_spacing k=%0d got=%0d required %0d", k,
                         trig_time[b[5:0]] - trig_time[a[5:0]], SETTLE + 2);
            end
        end
        checks++;
        if (d !== 32'h0000_0502) begin errors++; $display("FAIL basic_status got=%h required 00000502", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL basic_resp got=%h required 000000a5", d); end
    endtask

    task automatic test_majority();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h08, 32'd3, r);
        fill_seq(32'h11);
        resp_seq[1] = 32'h10;
        axi_write(6'h00, 32'h1, r);
        wait_done(d);
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h11) begin errors++; $display("FAIL majority_resp got=%h required 00000011", d); end
`ifdef PUF_RAW_CAPTURE_EN
        axi_read(6'h20, d, r);
        checks++;
        if (d !== 32'h11) begin errors++; $display("FAIL raw got=%h required 00000011", d); end
        axi_read(6'h24, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL unstable got=%h required 00000001", d); end
`else
        axi_read(6'h20, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL raw_off got=%h required 0", d); end
        axi_read(6'h24, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unstable_off got=%h required 0", d); end
`endif
        // Even count: bit0 sees 1,0 (tie -> 0), bit1 sees 1,1 (-> 1).
        axi_write(6'h08, 32'd2, r);
        fill_seq(32'h3);
        resp_seq[1] = 32'h2;
        axi_write(6'h00, 32'h1, r);
        wait_done(d);
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL tie_resp got=%h required 00000002", d); end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d;
        logic [1:0]  r;
        int base;
        axi_write(6'h08, 32'd4, r);
        fill_seq(32'h5A);
        base = trig_total;
        axi_write(6'h00, 32'h1, r);
        axi_read(6'h04, d, r);
        checks++;
        if (d[1:0] !== 2'b01) begin errors++; $display("FAIL busy_status got=%b required 01", d[1:0]); end
        axi_write(6'h10, 32'h1234_5678, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL busy_chal_bresp got=%b required 10", r); end
        checks++;
        if (puf_challenge !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL busy_challenge got=%h required deadbeef00000001", puf_challenge);
        end
        axi_write(6'h08, 32'd7, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL busy_neval_bresp got=%b required 10", r); end
        axi_write(6'h00, 32'h1, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL busy_start_bresp got=%b required 00", r); end
        wait_done(d);
        checks++;
        if (trig_total - base !== 4) begin
            errors++; $display("FAIL busy_trig_count got=%0d required 4", trig_total - base);
        end
        checks++;
        if (d !== 32'h0000_0402) begin errors++; $display("FAIL busy_final_status got=%h required 00000402", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL busy_resp got=%h required 0000005a", d); end
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL busy_neval_kept got=%h required 4", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic [1:0]  r;
        int base, n;
        axi_write(6'h08, 32'd5, r);
        fill_seq(32'hFF);
        base = trig_total;
        axi_write(6'h00, 32'h1, r);
        n = 0;
        while (trig_total - base < 2 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (trig_total - base < 2) begin errors++; $display("FAIL abort_wait got=%0d required 2", trig_total - base); end
        axi_write(6'h00, 32'h2, r);
        @(negedge ACLK);
        checks++;
        if (puf_trigger !== 1'b0) begin errors++; $display("FAIL abort_trigger got=%b required 0", puf_trigger); end
        axi_read(6'h04, d, r);
        checks++;
        if (d[1:0] !== 2'b00) begin errors++; $display("FAIL abort_status got=%b required 00", d[1:0]); end
        repeat (60) @(negedge ACLK);
        checks++;
        if (trig_total - base !== 2) begin
            errors++; $display("FAIL abort_trig_count got=%0d required 2", trig_total - base);
        end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL abort_resp got=%h required 0000005a", d); end
        // START together with ABORT in IDLE must not start an evaluation.
        base = trig_total;
        axi_write(6'h00, 32'h3, r);
        repeat (40) @(negedge ACLK);
        axi_read(6'h04, d, r);
        checks++;
        if (trig_total - base !== 0 || d[1:0] !== 2'b00) begin
            errors++; $display("FAIL start_abort_idle trig=%0d status=%b required 0 and 00", trig_total - base, d[1:0]);
        end
    endtask

    task automatic test_neval0();
        logic [31:0] d;
        logic [1:0]  r;
        int base;
        axi_write(6'h08, 32'd0, r);
        fill_seq(32'h0F0F);
        base = trig_total;
        axi_write(6'h00, 32'h1, r);
        wait_done(d);
        checks++;
        if (trig_total - base !== 1) begin
            errors++; $display("FAIL neval0_trig_count got=%0d required 1", trig_total - base);
        end
        checks++;
        if (d !== 32'h0000_0102) begin errors++; $display("FAIL neval0_status got=%h required 00000102", d); end
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h0F0F) begin errors++; $display("FAIL neval0_resp got=%h required 00000f0f", d); end
        axi_read(6'h3C, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b00) begin
            errors++; $display("FAIL unmapped_read data=%h rresp=%b required 0 and 00", d, r);
        end
        axi_write(6'h38, 32'hFFFF_FFFF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL unmapped_write bresp=%b required 00", r); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) resp_seq[i] = '0;
        for (int i = 0; i < 64; i++) trig_time[i] = 0;
        test_reset();
        test_basic();
        test_majority();
        test_busy_writes();
        test_abort();
        test_neval0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
